// File: rtl/polygon_color_arbiter_if.sv
// Handshake bundle between the pixel-candidate source, the colour arbiter and the
// frame-write stage: candidate set in, resolved colour out.
interface polygon_color_arbiter_if #(
   parameter int unsigned N_CH    = 5,
   parameter int unsigned MASK_W  = 4,
   parameter int unsigned COLOR_W = 9,
   parameter int unsigned LAYER_W = 3,
   parameter int unsigned CH_W    = $clog2(N_CH)
);
   logic                      in_valid;
   logic                      in_ready;
   logic [N_CH*MASK_W-1:0]    in_mask;
   logic [N_CH*COLOR_W-1:0]   in_color;
   logic [N_CH*LAYER_W-1:0]   in_layer;
   logic [1:0]                in_mode;
   logic                      out_valid;
   logic                      out_ready;
   logic [COLOR_W-1:0]        out_color;
   logic                      out_hit;
   logic [CH_W-1:0]           out_ch;

   modport master (
      output in_valid, in_mask, in_color, in_layer, in_mode, out_ready,
      input  in_ready, out_valid, out_color, out_hit, out_ch
   );

   modport slave (
      input  in_valid, in_mask, in_color, in_layer, in_mode, out_ready,
      output in_ready, out_valid, out_color, out_hit, out_ch
   );
endinterface

// File: rtl/polygon_color_arbiter.sv
// Two-stage per-pixel polygon colour arbiter: S1 captures eligibility, S2 holds the
// resolved winner behind a valid/ready output. Keeps a saturating miss counter.
module polygon_color_arbiter #(
   parameter int unsigned N_CH      = 5,
   parameter int unsigned MASK_W    = 4,
   parameter int unsigned COLOR_W   = 9,
   parameter int unsigned LAYER_W   = 3,
   parameter int unsigned INVISIBLE = 510,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned CH_W      = $clog2(N_CH)
) (
   input  logic                   clk,
   input  logic                   reset,
   polygon_color_arbiter_if.slave bus,
   input  logic                   clr_cnt,
   output logic [CNT_W-1:0]       miss_cnt
);
   localparam logic [COLOR_W-1:0] InvColor = COLOR_W'(INVISIBLE);

   logic                     adv1, adv2;
   logic [N_CH-1:0]          elig;
   logic [N_CH*LAYER_W-1:0]  layer_m;
   logic [N_CH*COLOR_W-1:0]  color_m;

   logic                     s1_valid_q;
   logic [N_CH-1:0]          s1_elig_q;
   logic [N_CH*LAYER_W-1:0]  s1_layer_q;
   logic [N_CH*COLOR_W-1:0]  s1_color_q;
   logic                     s1_lmode_q;

   logic                     win_found;
   logic [CH_W-1:0]          win_ch;
   logic [LAYER_W-1:0]       win_layer;
   logic [COLOR_W-1:0]       win_color;

   logic                     out_valid_q, out_hit_q;
   logic [COLOR_W-1:0]       out_color_q;
   logic [CH_W-1:0]          out_ch_q;
   logic [CNT_W-1:0]         miss_cnt_q;

   assign adv2         = !out_valid_q || bus.out_ready;
   assign adv1         = !s1_valid_q || adv2;
   assign bus.in_ready = adv1;

   // Ineligible channels are zeroed so S1 only carries what the resolver may use.
   always_comb begin
      elig    = '0;
      layer_m = '0;
      color_m = '0;
      for (int i = 0; i < N_CH; i++) begin
         elig[i] = (&bus.in_mask[i*MASK_W +: MASK_W]) &&
                   !(bus.in_mode[1] && (bus.in_color[i*COLOR_W +: COLOR_W] == InvColor));
         layer_m[i*LAYER_W +: LAYER_W] = elig[i] ? bus.in_layer[i*LAYER_W +: LAYER_W] : '0;
         color_m[i*COLOR_W +: COLOR_W] = elig[i] ? bus.in_color[i*COLOR_W +: COLOR_W] : '0;
      end
   end

   // Ascending scan with strict '>' keeps layer ties on the lowest index.
   always_comb begin
      win_found = 1'b0;
      win_ch    = '0;
      win_layer = '0;
      win_color = InvColor;
      for (int i = 0; i < N_CH; i++) begin
         if (s1_elig_q[i] &&
             (!win_found || (s1_lmode_q && (s1_layer_q[i*LAYER_W +: LAYER_W] > win_layer)))) begin
            win_found = 1'b1;
            win_ch    = CH_W'(i);
            win_layer = s1_layer_q[i*LAYER_W +: LAYER_W];
            win_color = s1_color_q[i*COLOR_W +: COLOR_W];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         s1_elig_q  <= '0;
         s1_layer_q <= '0;
         s1_color_q <= '0;
         s1_lmode_q <= 1'b0;
      end else if (adv1) begin
         s1_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            s1_elig_q  <= elig;
            s1_layer_q <= layer_m;
            s1_color_q <= color_m;
            s1_lmode_q <= bus.in_mode[0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         out_color_q <= '0;
         out_hit_q   <= 1'b0;
         out_ch_q    <= '0;
      end else if (adv2) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_color_q <= win_color;
            out_hit_q   <= win_found;
            out_ch_q    <= win_ch;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         miss_cnt_q <= '0;
      end else if (clr_cnt) begin
         miss_cnt_q <= '0;
      end else if (out_valid_q && bus.out_ready && !out_hit_q && !(&miss_cnt_q)) begin
         miss_cnt_q <= miss_cnt_q + 1'b1;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_color = out_color_q;
   assign bus.out_hit   = out_hit_q;
   assign bus.out_ch    = out_ch_q;
   assign miss_cnt      = miss_cnt_q;
endmodule

// File: tb/tb_polygon_color_arbiter.sv
// Randomised and directed bench for polygon_color_arbiter against a queue-based
// reference model; a second instance with a 2-bit miss counter checks saturation.
module tb_polygon_color_arbiter;
   localparam int unsigned N_CH    = 5;
   localparam int unsigned MASK_W  = 4;
   localparam int unsigned COLOR_W = 9;
   localparam int unsigned LAYER_W = 3;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned CH_W    = $clog2(N_CH);
   localparam int          INV     = 510;

   typedef struct packed {
      logic [COLOR_W-1:0] color;
      logic               hit;
      logic [CH_W-1:0]    ch;
   } res_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic clr_cnt = 1'b0;
   logic [CNT_W-1:0] miss_cnt;
   logic [1:0]       miss_cnt2;

   always #5 clk = ~clk;

   polygon_color_arbiter_if #(.N_CH(N_CH), .MASK_W(MASK_W), .COLOR_W(COLOR_W),
                              .LAYER_W(LAYER_W)) bus ();
   polygon_color_arbiter_if #(.N_CH(N_CH), .MASK_W(MASK_W), .COLOR_W(COLOR_W),
                              .LAYER_W(LAYER_W)) bus2 ();

   assign bus2.in_valid  = bus.in_valid;
   assign bus2.in_mask   = bus.in_mask;
   assign bus2.in_color  = bus.in_color;
   assign bus2.in_layer  = bus.in_layer;
   assign bus2.in_mode   = bus.in_mode;
   assign bus2.out_ready = bus.out_ready;

   polygon_color_arbiter #(.N_CH(N_CH), .MASK_W(MASK_W), .COLOR_W(COLOR_W),
      .LAYER_W(LAYER_W), .INVISIBLE(INV), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave), .clr_cnt(clr_cnt), .miss_cnt(miss_cnt));

   polygon_color_arbiter #(.N_CH(N_CH), .MASK_W(MASK_W), .COLOR_W(COLOR_W),
      .LAYER_W(LAYER_W), .INVISIBLE(INV), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2.slave), .clr_cnt(clr_cnt), .miss_cnt(miss_cnt2));

   int tests = 0;
   int fails = 0;
   int n_deliv = 0;
   res_t exp_q[$];
   int vm[N_CH], vc[N_CH], vl[N_CH];

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: gather eligible channels, then pick by rule.
   function automatic res_t model(input logic [N_CH*MASK_W-1:0] m,
                                  input logic [N_CH*COLOR_W-1:0] c,
                                  input logic [N_CH*LAYER_W-1:0] l, input logic [1:0] mode);
      res_t r;
      int cand[$];
      int best;
      r.color = COLOR_W'(INV);
      r.hit = 1'b0;
      r.ch = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (int'(m[i*MASK_W +: MASK_W]) == (1 << MASK_W) - 1 &&
             !(mode[1] && int'(c[i*COLOR_W +: COLOR_W]) == INV))
            cand.push_back(i);
      end
      if (cand.size() > 0) begin
         best = cand[0];
         if (mode[0]) begin
            int top = -1;
            foreach (cand[k]) if (int'(l[cand[k]*LAYER_W +: LAYER_W]) > top)
               top = int'(l[cand[k]*LAYER_W +: LAYER_W]);
            for (int k = cand.size() - 1; k >= 0; k--)
               if (int'(l[cand[k]*LAYER_W +: LAYER_W]) == top) best = cand[k];
         end
         r.hit = 1'b1;
         r.ch = CH_W'(best);
         r.color = c[best*COLOR_W +: COLOR_W];
      end
      return r;
   endfunction

   int   m16 = 0;
   int   m2 = 0;
   logic held_v = 1'b0;
   res_t held;

   always @(negedge clk) begin
      res_t e;
      logic miss_now;
      if (!reset) begin
         exp_q.delete();
         m16 = 0;
         m2 = 0;
         held_v = 1'b0;
      end else begin
         check("miss_cnt", int'(miss_cnt), m16);
         check("miss_cnt_w2", int'(miss_cnt2), m2);
         check("in_ready", int'(bus.in_ready), int'(!(exp_q.size() == 2 && !bus.out_ready)));
         if (held_v) begin
            check("stall_valid", int'(bus.out_valid), 1);
            check("stall_color", int'(bus.out_color), int'(held.color));
            check("stall_hit", int'(bus.out_hit), int'(held.hit));
            check("stall_ch", int'(bus.out_ch), int'(held.ch));
         end
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.in_mask, bus.in_color, bus.in_layer, bus.in_mode));
         miss_now = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("out_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("out_color", int'(bus.out_color), int'(e.color));
               check("out_hit", int'(bus.out_hit), int'(e.hit));
               check("out_ch", int'(bus.out_ch), int'(e.ch));
               miss_now = !e.hit;
               n_deliv++;
            end
         end
         if (clr_cnt) begin
            m16 = 0;
            m2 = 0;
         end else if (miss_now) begin
            if (m16 < (1 << CNT_W) - 1) m16++;
            if (m2 < 3) m2++;
         end
         held_v = bus.out_valid && !bus.out_ready;
         held.color = bus.out_color;
         held.hit = bus.out_hit;
         held.ch = bus.out_ch;
      end
   end

   task automatic drive_v();
      for (int i = 0; i < N_CH; i++) begin
         bus.in_mask[i*MASK_W +: MASK_W]    = MASK_W'(vm[i]);
         bus.in_color[i*COLOR_W +: COLOR_W] = COLOR_W'(vc[i]);
         bus.in_layer[i*LAYER_W +: LAYER_W] = LAYER_W'(vl[i]);
      end
   endtask

   task automatic drive_rand();
      for (int i = 0; i < N_CH; i++) begin
         bus.in_mask[i*MASK_W +: MASK_W] = ($urandom % 2) ? '1 : MASK_W'($urandom);
         bus.in_color[i*COLOR_W +: COLOR_W] = ($urandom % 4 == 0) ? COLOR_W'(INV)
                                                                  : COLOR_W'($urandom);
         bus.in_layer[i*LAYER_W +: LAYER_W] = LAYER_W'($urandom);
      end
      bus.in_mode = 2'($urandom);
   endtask

   // One pixel from vm/vc/vl with out_ready high; literal result after two edges.
   task automatic directed(input string name, input logic [1:0] mode, input int ecol,
                           input int ehit, input int ech);
      bus.out_ready = 1'b1;
      drive_v();
      bus.in_mode = mode;
      bus.in_valid = 1'b1;
      check({name, "_in_ready"}, int'(bus.in_ready), 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check({name, "_lat1"}, int'(bus.out_valid), 0);
      @(posedge clk); #1;
      check({name, "_valid"}, int'(bus.out_valid), 1);
      check({name, "_color"}, int'(bus.out_color), ecol);
      check({name, "_hit"}, int'(bus.out_hit), ehit);
      check({name, "_ch"}, int'(bus.out_ch), ech);
      @(posedge clk); #1;
   endtask

   task automatic miss_pixel(input string name);
      vm = '{7, 14, 0, 3, 11};
      vc = '{1, 2, 3, 4, 5};
      vl = '{0, 0, 0, 0, 0};
      directed(name, 2'd0, INV, 0, 0);
   endtask

   initial begin
      int base;
      int sent;
      int pat[8];
      pat = '{1, 0, 0, 1, 0, 1, 1, 1};
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_mask = '0;
      bus.in_color = '0;
      bus.in_layer = '0;
      bus.in_mode = '0;
      #12;
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_color", int'(bus.out_color), 0);
      check("rst_out_hit", int'(bus.out_hit), 0);
      check("rst_out_ch", int'(bus.out_ch), 0);
      check("rst_miss_cnt", int'(miss_cnt), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", int'(bus.in_ready), 1);

      vm = '{15, 15, 0, 0, 0};
      vc = '{10, 20, 30, 40, 50};
      vl = '{0, 7, 0, 0, 0};
      directed("fixed", 2'd0, 10, 1, 0);
      vm = '{15, 15, 15, 15, 15};
      vc = '{100, 101, 102, 103, 104};
      vl = '{1, 5, 5, 2, 0};
      directed("layer", 2'd1, 101, 1, 1);
      vm = '{15, 0, 0, 15, 0};
      vc = '{510, 11, 12, 77, 13};
      vl = '{3, 0, 0, 1, 0};
      directed("skip", 2'd2, 77, 1, 3);
      directed("noskip", 2'd0, 510, 1, 0);
      directed("skip_layer", 2'd3, 77, 1, 3);

      for (int i = 0; i < 3; i++) miss_pixel("miss");
      check("miss3", int'(miss_cnt), 3);
      check("miss3_w2", int'(miss_cnt2), 3);
      // Fourth miss parked in S2, then cleared on its delivery cycle.
      bus.out_ready = 1'b0;
      drive_v();
      bus.in_mode = 2'd0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("miss4_parked", int'(bus.out_valid), 1);
      check("miss4_before", int'(miss_cnt), 3);
      bus.out_ready = 1'b1;
      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      check("clr_cnt_prio", int'(miss_cnt), 0);
      check("clr_cnt_prio_w2", int'(miss_cnt2), 0);
      for (int i = 0; i < 5; i++) miss_pixel("miss5");
      check("miss5", int'(miss_cnt), 5);
      check("miss5_sat_w2", int'(miss_cnt2), 3);

      // Back-pressure stream of 8 pixels.
      base = n_deliv;
      sent = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         bus.out_ready = (sent < 8 || cyc < 16) ? pat[cyc % 8][0] : 1'b1;
         bus.in_valid = (sent < 8);
         drive_rand();
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) sent++;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      check("bp_delivered", n_deliv - base, 8);

      // Reset with both stages full.
      bus.out_ready = 1'b0;
      vm = '{0, 0, 0, 0, 0};
      drive_v();
      bus.in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("full_in_ready", int'(bus.in_ready), 0);
      check("full_out_valid", int'(bus.out_valid), 1);
      #2 reset = 1'b0;
      #1;
      check("midrst_out_valid", int'(bus.out_valid), 0);
      check("midrst_miss_cnt", int'(miss_cnt), 0);
      check("midrst_miss_cnt_w2", int'(miss_cnt2), 0);
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("postrst_in_ready", int'(bus.in_ready), 1);
      check("postrst_out_valid", int'(bus.out_valid), 0);
      vm = '{0, 0, 15, 15, 0};
      vc = '{1, 2, 33, 44, 5};
      vl = '{0, 0, 2, 6, 0};
      directed("postrst", 2'd1, 44, 1, 3);

      // Random traffic.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bus.in_valid = ($urandom % 4 != 0);
         bus.out_ready = ($urandom % 3 != 0);
         clr_cnt = ($urandom % 50 == 0);
         drive_rand();
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      clr_cnt = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("drain_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
